// File: rtl/ctr_prog_pkg.sv
// ctr_prog_pkg: shared types for the programmable counter.
// End-of-count mode encodings and the RUN/DONE state type.
package ctr_prog_pkg;

  // End-of-count behaviour; 2'b11 is reserved and treated as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // RUN counts normally; DONE freezes the counter after a one-shot terminal event.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage : ctr_prog_pkg

// File: rtl/ctr_prog_step.sv
// ctr_prog_step: combinational next-count and terminal-condition logic.
// Given the current count, direction, limit and mode, it produces the value
// one enabled step would produce, and flags whether that step is terminal.
module ctr_prog_step
  import ctr_prog_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             term,
  output logic             oneshot_end
);

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  mode_t mode_s;
  assign mode_s = mode_t'(mode);

  // Terminal test, step value and one-shot end flag for the current count.
  always_comb begin
    term        = 1'b0;
    next_count  = count;
    oneshot_end = 1'b0;

    // Up: at or beyond the limit is terminal, so an over-limit load ends at once.
    if (up_dn) begin
      term = (count >= limit);
    end else begin
      term = (count == ZERO_C);
    end

    if (term) begin
      case (mode_s)
        MODE_SAT: begin
          next_count = count;
        end
        MODE_ONESHOT: begin
          next_count  = count;
          oneshot_end = 1'b1;
        end
        default: begin
          // Wrap (and reserved): up restarts at 0, down reloads the limit.
          if (up_dn) begin
            next_count = ZERO_C;
          end else begin
            next_count = limit;
          end
        end
      endcase
    end else begin
      if (up_dn) begin
        next_count = count + ONE_C;
      end else begin
        next_count = count - ONE_C;
      end
    end
  end

endmodule : ctr_prog_step

// File: rtl/ctr_prog.sv
// ctr_prog: programmable up/down counter with load, limit, wrap/saturate/
// one-shot end-of-count modes and a registered terminal-count pulse.
// Optional feature macro: CTR_PROG_CAPTURE_EN adds capture/cap_val, which
// snapshots the pre-edge count on any edge where capture is high.
module ctr_prog
  import ctr_prog_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
`ifdef CTR_PROG_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             done_r;
  logic [WIDTH-1:0] step_val_s;
  logic             term_s;
  logic             oneshot_end_s;

  ctr_prog_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count       (count_r),
    .up_dn       (up_dn),
    .limit       (limit),
    .mode        (mode),
    .next_count  (step_val_s),
    .term        (term_s),
    .oneshot_end (oneshot_end_s)
  );

  // Next-state, next-count and terminal pulse; load beats enable, DONE ignores enable.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;

    if (load) begin
      count_nxt_s = load_val;
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (enable) begin
            count_nxt_s = step_val_s;
            tc_nxt_s    = term_s;
            if (oneshot_end_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            count_nxt_s = count_r;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // Counter, FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
      count_r <= RESET_VAL;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign done  = done_r;

`ifdef CTR_PROG_CAPTURE_EN
  logic [WIDTH-1:0] cap_r;

  // Snapshot of the pre-edge count; active in every state and alongside load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_r <= {WIDTH{1'b0}};
    end else if (capture) begin
      cap_r <= count_r;
    end else begin
      cap_r <= cap_r;
    end
  end

  assign cap_val = cap_r;
`endif

endmodule : ctr_prog

// File: tb/tb_ctr_prog.sv
// tb_ctr_prog: directed self-checking bench for ctr_prog at WIDTH=8.
module tb_ctr_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic [1:0]   mode;
  logic [W-1:0] count;
  logic         tc;
  logic         done;
`ifdef CTR_PROG_CAPTURE_EN
  logic         capture;
  logic [W-1:0] cap_val;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  ctr_prog #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
`ifdef CTR_PROG_CAPTURE_EN
    .capture  (capture),
    .cap_val  (cap_val),
`endif
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] c, input logic t, input logic d);
    check({tag, ".count"}, {56'd0, count}, {56'd0, c});
    check({tag, ".tc"},    {63'd0, tc},    {63'd0, t});
    check({tag, ".done"},  {63'd0, done},  {63'd0, d});
  endtask

  initial begin
    logic [W-1:0] exp_up [8];
    logic         exp_tc [8];
    logic [W-1:0] exp_ds [5];
    logic         exp_dt [5];
    exp_up = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    exp_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_ds = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    exp_dt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = 8'h00; limit = 8'h05; mode = 2'b00;
`ifdef CTR_PROG_CAPTURE_EN
    capture = 1'b0;
`endif
    tick(); tick();
    chk3("reset", 8'h00, 1'b0, 1'b0);
`ifdef CTR_PROG_CAPTURE_EN
    check("reset.cap_val", {56'd0, cap_val}, 64'd0);
`endif

    // Up, wrap, limit 5.
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("upwrap%0d.count", i), {56'd0, count}, {56'd0, exp_up[i]});
      check($sformatf("upwrap%0d.tc", i), {63'd0, tc}, {63'd0, exp_tc[i]});
    end

    // Down, saturate from a load of 2.
    enable = 1'b0; up_dn = 1'b0; mode = 2'b01; load = 1'b1; load_val = 8'h02;
    tick();
    check("dsat0.count", {56'd0, count}, {56'd0, exp_ds[0]});
    check("dsat0.tc", {63'd0, tc}, {63'd0, exp_dt[0]});
    load = 1'b0; enable = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("dsat%0d.count", i), {56'd0, count}, {56'd0, exp_ds[i]});
      check($sformatf("dsat%0d.tc", i), {63'd0, tc}, {63'd0, exp_dt[i]});
    end

    // One-shot up, limit 3, from 0.
    enable = 1'b0; load = 1'b1; load_val = 8'h00; up_dn = 1'b1; mode = 2'b10; limit = 8'h03;
    tick();
    load = 1'b0; enable = 1'b1;
    tick(); chk3("os1", 8'd1, 1'b0, 1'b0);
    tick(); chk3("os2", 8'd2, 1'b0, 1'b0);
    tick(); chk3("os3", 8'd3, 1'b0, 1'b0);
    tick(); chk3("os_end", 8'd3, 1'b1, 1'b1);
    tick(); chk3("os_hold", 8'd3, 1'b0, 1'b1);
    mode = 2'b00;
    tick(); chk3("os_modechg", 8'd3, 1'b0, 1'b1);
    mode = 2'b10; load = 1'b1; load_val = 8'h07;
    tick(); chk3("os_load7", 8'd7, 1'b0, 1'b0);
    load = 1'b0;
    tick(); chk3("os_over", 8'd7, 1'b1, 1'b1);

    // Load wins over enable; reset wins over load.
    mode = 2'b00; limit = 8'hFF; load = 1'b1; load_val = 8'h10;
    tick(); chk3("load_en", 8'h10, 1'b0, 1'b0);
    reset = 1'b1; load_val = 8'h33;
    tick(); chk3("reset_load", 8'h00, 1'b0, 1'b0);

    // Down, wrap, limit 0xFF from 0.
    reset = 1'b0; load = 1'b0; up_dn = 1'b0; enable = 1'b1;
    tick(); chk3("dwrap_ff", 8'hFF, 1'b1, 1'b0);
    tick(); chk3("dwrap_fe", 8'hFE, 1'b0, 1'b0);

    // Hold when enable is low.
    enable = 1'b0;
    tick(); chk3("hold", 8'hFE, 1'b0, 1'b0);

    // limit 0 counting up: every step terminal; down from 0 wrap reloads 0.
    up_dn = 1'b1; limit = 8'h00; load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0; enable = 1'b1;
    tick(); chk3("lim0_a", 8'h00, 1'b1, 1'b0);
    tick(); chk3("lim0_b", 8'h00, 1'b1, 1'b0);
    up_dn = 1'b0;
    tick(); chk3("lim0_dn", 8'h00, 1'b1, 1'b0);

    // Reserved mode behaves as wrap.
    up_dn = 1'b1; limit = 8'h02; mode = 2'b11; load = 1'b1; load_val = 8'h02; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    tick(); chk3("rsvd_wrap", 8'h00, 1'b1, 1'b0);

`ifdef CTR_PROG_CAPTURE_EN
    // Capture while stepping, then reset clears it.
    mode = 2'b00; limit = 8'h20; load = 1'b1; load_val = 8'h03; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    capture = 1'b1;
    tick();
    check("cap.count", {56'd0, count}, 64'd5);
    check("cap.cap_val", {56'd0, cap_val}, 64'd4);
    capture = 1'b0;
    tick();
    check("cap.keep", {56'd0, cap_val}, 64'd4);
    capture = 1'b1; load = 1'b1; load_val = 8'h40;
    tick();
    check("cap.load", {56'd0, cap_val}, 64'd6);
    reset = 1'b1;
    tick();
    check("cap.reset", {56'd0, cap_val}, 64'd0);
    reset = 1'b0; capture = 1'b0; load = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ctr_prog
